// File: rtl/ssp_pkg.sv
// SSP arbiter shared definitions: FSM encoding, defaults, ID width helper.
// Timeout feature is enabled by defining SSP_ARB_TIMEOUT_EN.
package ssp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_NREQ        = 4;
  localparam int DEF_TIMEOUT_CYC = 32;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssp_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_id.
// Produces both the one-hot grant and its index.
module ssp_rr_arbiter
  import ssp_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [id_w(NREQ)-1:0]   last_id,
  output logic [NREQ-1:0]         gnt_oh,
  output logic [id_w(NREQ)-1:0]   gnt_idx
);

  localparam int IW = id_w(NREQ);

  int          p;
  logic [IW-1:0] pi;
  logic        hit;

  // scan upward from last_id+1, wrapping, first hit wins
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    hit     = 1'b0;
    p       = 0;
    pi      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      p  = (int'(last_id) + k) % NREQ;
      pi = IW'(p);
      if (!hit && req[pi]) begin
        hit         = 1'b1;
        gnt_oh[pi]  = 1'b1;
        gnt_idx     = pi;
      end
    end
  end

endmodule

// File: rtl/ssp_arbiter.sv
// Shares one SSP transmit/receive engine among NREQ requesters.
// Define SSP_ARB_TIMEOUT_EN to abort transfers after TIMEOUT_CYC cycles.
module ssp_arbiter
  import ssp_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*8-1:0]      req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        err,
  output logic                   busy,
  output logic                   tx_ready,
  output logic [7:0]             TxData,
  input  logic                   transmit_complete,
  input  logic                   rx_ready,
  input  logic [7:0]             RxData,
  output logic                   rx_valid,
  output logic [7:0]             rx_data,
  output logic [id_w(NREQ)-1:0]  rx_id
);

  localparam int IW = id_w(NREQ);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [IW-1:0]   own_q, own_d;
  logic [IW-1:0]   last_q, last_d;
  logic [7:0]      hold_q, hold_d;
  logic [NREQ-1:0] sel_oh;
  logic [IW-1:0]   sel_idx;
  logic [7:0]      sel_byte;
  logic            sync1_q, sync2_q;
  logic            rxv_q;
  logic [7:0]      rxd_q;
  logic [IW-1:0]   rxid_q;

`ifdef SSP_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]   tmr_q, tmr_d, tmr_inc;
  logic [NREQ-1:0] err_q, err_d;
  assign tmr_inc = tmr_q + 1'b1;
`endif

  ssp_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (req),
    .last_id (last_q),
    .gnt_oh  (sel_oh),
    .gnt_idx (sel_idx)
  );

  // byte of the requester picked by the round-robin
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NREQ; i++)
      if (sel_oh[i]) sel_byte = req_data[i*8 +: 8];
  end

  // next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    own_d   = own_q;
    last_d  = last_q;
    hold_d  = hold_q;
`ifdef SSP_ARB_TIMEOUT_EN
    err_d   = '0;
    tmr_d   = tmr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          hold_d  = sel_byte;
          gnt_d   = sel_oh;
          own_d   = sel_idx;
          state_d = ISSUE;
`ifdef SSP_ARB_TIMEOUT_EN
          tmr_d   = '0;
`endif
        end
      end
      ISSUE: begin
        if (!transmit_complete) state_d = SHIFT;
      end
      SHIFT: begin
        if (transmit_complete) begin
          state_d = DONE;
          gnt_d   = '0;
          done_d  = gnt_q;
          last_d  = own_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef SSP_ARB_TIMEOUT_EN
    if (state_q == ISSUE || state_q == SHIFT) begin
      tmr_d = tmr_inc;
      if (tmr_inc == TW'(TIMEOUT_CYC)) begin
        state_d = IDLE;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = gnt_q;
        last_d  = own_q;
      end
    end
`endif
  end

  // FSM and transfer bookkeeping registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      own_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      hold_q  <= '0;
`ifdef SSP_ARB_TIMEOUT_EN
      err_q   <= '0;
      tmr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      own_q   <= own_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
`ifdef SSP_ARB_TIMEOUT_EN
      err_q   <= err_d;
      tmr_q   <= tmr_d;
`endif
    end
  end

  // rx_ready synchroniser; rising edge of the second flop captures a byte
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      rxv_q   <= 1'b0;
      rxd_q   <= '0;
      rxid_q  <= '0;
    end else begin
      sync1_q <= rx_ready;
      sync2_q <= sync1_q;
      rxv_q   <= sync1_q & ~sync2_q;
      if (sync1_q && !sync2_q) begin
        rxd_q  <= RxData;
        rxid_q <= last_q;
      end
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign tx_ready = (state_q == ISSUE);
  assign TxData   = hold_q;
  assign rx_valid = rxv_q;
  assign rx_data  = rxd_q;
  assign rx_id    = rxid_q;

`ifdef SSP_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_ssp_arbiter.sv
// Scoreboard bench for ssp_arbiter: stimulus pushes expectations,
// a negedge monitor pops and compares grants, done/err and rx bytes.
module tb_ssp_arbiter;

  localparam int NREQ = 4;

  logic            PCLK;
  logic            PRESETn;
  logic [3:0]      req;
  logic [31:0]     req_data;
  logic [3:0]      gnt, done, err;
  logic            busy, tx_ready;
  logic [7:0]      TxData;
  logic            transmit_complete;
  logic            rx_ready;
  logic [7:0]      RxData;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic [1:0]      rx_id;

  ssp_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(32)) dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .req               (req),
    .req_data          (req_data),
    .gnt               (gnt),
    .done              (done),
    .err               (err),
    .busy              (busy),
    .tx_ready          (tx_ready),
    .TxData            (TxData),
    .transmit_complete (transmit_complete),
    .rx_ready          (rx_ready),
    .RxData            (RxData),
    .rx_valid          (rx_valid),
    .rx_data           (rx_data),
    .rx_id             (rx_id)
  );

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t gq[$];
  int   dq[$];
  int   eq[$];
  exp_t rq[$];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic ssp_en = 1'b1;
  logic txr_prev = 1'b0;
  logic [7:0] cur_data = 8'h00;

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // SSP engine model: accept a word, shift for 3 cycles, report idle
  initial begin
    transmit_complete = 1'b1;
    forever begin
      @(negedge PCLK);
      if (ssp_en && tx_ready && transmit_complete) begin
        transmit_complete = 1'b0;
        repeat (3) @(negedge PCLK);
        transmit_complete = 1'b1;
      end
    end
  end

  // monitor
  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (tx_ready && !txr_prev) begin
        if (gq.size() == 0) check("unexp_issue", 32'(gnt), 32'h0);
        else begin
          exp_t e;
          e = gq.pop_front();
          check("issue_gnt", 32'(gnt), 32'(1) << e.id);
          check("issue_data", 32'(TxData), 32'(e.data));
          cur_data <= e.data;
        end
      end else if (gnt != 4'h0) begin
        check("txdata_hold", 32'(TxData), 32'(cur_data));
      end
      if (gnt != 4'h0) check("gnt_onehot", 32'($countones(gnt)), 32'd1);
      if (|done) begin
        if (dq.size() == 0) check("unexp_done", 32'(done), 32'h0);
        else begin
          int id;
          id = dq.pop_front();
          check("done", 32'(done), 32'(1) << id);
          done_cnt++;
        end
      end
      if (|err) begin
        if (eq.size() == 0) check("unexp_err", 32'(err), 32'h0);
        else begin
          int id;
          id = eq.pop_front();
          check("err", 32'(err), 32'(1) << id);
        end
      end
      if (rx_valid) begin
        if (rq.size() == 0) check("unexp_rx", 32'(rx_data), 32'h0);
        else begin
          exp_t e;
          e = rq.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("rx_id", 32'(rx_id), 32'(e.id));
        end
      end
      txr_prev <= tx_ready;
    end else begin
      txr_prev <= 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge PCLK);
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge PCLK);
      #1;
      n++;
    end while (busy && n < budget);
    check("idle_wait", 32'(busy), 32'h0);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge PCLK);
      #1;
      n++;
    end while (done_cnt < target && n < budget);
    check("done_wait", 32'(done_cnt), 32'(target));
  endtask

  task automatic single(input int id, input logic [7:0] d);
    @(negedge PCLK);
    req_data[id*8 +: 8] = d;
    req = 4'(1) << id;
    gq.push_back('{id, d});
    dq.push_back(id);
    @(negedge PCLK);
    #1;
    check("lat1_txr", 32'(tx_ready), 32'h1);
    req = 4'h0;
    wait_idle(40);
  endtask

  initial begin
    int lat;
    int n;
    PRESETn  = 1'b0;
    req      = 4'h0;
    req_data = 32'h0;
    rx_ready = 1'b0;
    RxData   = 8'h00;
    repeat (2) @(negedge PCLK);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_txr", 32'(tx_ready), 32'h0);
    check("rst_txd", 32'(TxData), 32'h0);
    check("rst_rxv", 32'(rx_valid), 32'h0);
    check("rst_rxd", 32'(rx_data), 32'h0);
    check("rst_rxid", 32'(rx_id), 32'h0);
    PRESETn = 1'b1;

    // single request with early req drop
    single(2, 8'hA5);

    // contention from reset: 0,1,2,3,0
    do_reset();
    @(negedge PCLK);
    req_data = 32'h43322110;
    req = 4'hF;
    gq.push_back('{0, 8'h10});
    gq.push_back('{1, 8'h21});
    gq.push_back('{2, 8'h32});
    gq.push_back('{3, 8'h43});
    gq.push_back('{0, 8'h10});
    foreach (gq[i]) dq.push_back(gq[i].id);
    wait_done(done_cnt + 5, 60);
    req = 4'h0;
    wait_idle(10);

    // receive after a transfer owned by 1
    single(1, 8'h77);
    @(negedge PCLK);
    RxData = 8'h3C;
    rx_ready = 1'b1;
    rq.push_back('{1, 8'h3C});
    lat = 0;
    n = 0;
    do begin
      @(negedge PCLK);
      #1;
      n++;
      if (rx_valid && lat == 0) lat = n;
    end while (lat == 0 && n < 8);
    check("rx_lat_ok", 32'(lat >= 2 && lat <= 3), 32'h1);
    repeat (3) @(negedge PCLK);
    rx_ready = 1'b0;
    repeat (3) @(negedge PCLK);

    // rx edge launched during DONE is kept; owner becomes 3
    @(negedge PCLK);
    req_data[31:24] = 8'h99;
    req = 4'h8;
    gq.push_back('{3, 8'h99});
    dq.push_back(3);
    @(negedge PCLK);
    req = 4'h0;
    n = 0;
    do begin
      @(negedge PCLK);
      #1;
      n++;
    end while (!(|done) && n < 20);
    check("done_seen", 32'(done), 32'h8);
    RxData = 8'h5A;
    rx_ready = 1'b1;
    rq.push_back('{3, 8'h5A});
    repeat (5) @(negedge PCLK);
    rx_ready = 1'b0;
    wait_idle(10);

    // reset mid-SHIFT: no done, requester 0 first afterwards
    @(negedge PCLK);
    req_data[23:16] = 8'h11;
    req = 4'h4;
    gq.push_back('{2, 8'h11});
    n = 0;
    do begin
      @(negedge PCLK);
      #1;
      n++;
    end while (!(busy && !tx_ready && gnt != 4'h0) && n < 20);
    check("in_shift", 32'(gnt), 32'h4);
    PRESETn = 1'b0;
    #1;
    check("rst_mid_txr", 32'(tx_ready), 32'h0);
    check("rst_mid_gnt", 32'(gnt), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    req = 4'h0;
    repeat (5) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    req_data = 32'hD4C3B2A1;
    req = 4'hF;
    gq.push_back('{0, 8'hA1});
    dq.push_back(0);
    wait_done(done_cnt + 1, 20);
    req = 4'h0;
    wait_idle(10);

`ifdef SSP_ARB_TIMEOUT_EN
    // engine never starts: abort after 32 cycles with err
    ssp_en = 1'b0;
    @(negedge PCLK);
    req_data[15:8] = 8'h42;
    req = 4'h2;
    gq.push_back('{1, 8'h42});
    eq.push_back(1);
    @(negedge PCLK);
    #1;
    check("tmo_txr", 32'(tx_ready), 32'h1);
    req = 4'h0;
    n = 0;
    do begin
      @(negedge PCLK);
      #1;
      n++;
    end while (!(|err) && n < 40);
    check("tmo_cyc", 32'(n), 32'd32);
    check("tmo_busy", 32'(busy), 32'h0);
    check("tmo_gnt", 32'(gnt), 32'h0);
    ssp_en = 1'b1;
    repeat (3) @(negedge PCLK);
`endif

    repeat (4) @(negedge PCLK);
    check("gq_empty", 32'(gq.size()), 32'h0);
    check("dq_empty", 32'(dq.size()), 32'h0);
    check("eq_empty", 32'(eq.size()), 32'h0);
    check("rq_empty", 32'(rq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ssp_arbiter.md
SSP_ARBITER -- requirements
Module: ssp_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the SSP transmit/receive logic.
REQ-002 Parameter TIMEOUT_CYC, default 32: PCLK cycles allowed from grant to transmit_complete return.
REQ-003 PCLK  in  1  single clock; all logic on its rising edge.
REQ-004 PRESETn  in  1  asynchronous, active-low reset.
REQ-005 req  in  NREQ  per-requester transfer request, level.
REQ-006 req_data  in  NREQ*8  per-requester byte; slot i is bits [8i+7:8i].
REQ-007 gnt  out  NREQ  one-hot owner of the current transfer.
REQ-008 done  out  NREQ  one-cycle pulse to the owner at transfer end.
REQ-009 err  out  NREQ  one-cycle pulse to the owner on timeout abort.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 tx_ready  out  1  word-available strobe to the SSP logic.
REQ-012 TxData  out  8  byte presented to the SSP logic.
REQ-013 transmit_complete  in  1  high while the SSP logic is idle; low while shifting.
REQ-014 rx_ready  in  1  received-byte flag from the SSP logic; asynchronous to PCLK.
REQ-015 RxData  in  8  received byte; stable while rx_ready is high.
REQ-016 rx_valid  out  1  one-cycle pulse: new received byte.
REQ-017 rx_data  out  8  received byte; valid with rx_valid and held until the next rx_valid.
REQ-018 rx_id  out  clog2(NREQ)  index of the most recent transfer owner; valid with rx_valid.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, SHIFT and DONE.
REQ-020 IDLE: when any req is high, pick the first requester after last_id in round-robin order, latch its byte into hold, set gnt one-hot next cycle, and go to ISSUE.
REQ-021 In ISSUE, tx_ready=1 and TxData=hold; the first cycle req rises in IDLE has tx_ready high on the following cycle (latency 1).
REQ-022 ISSUE to SHIFT when transmit_complete=0 is sampled; tx_ready=0 from that cycle onward.
REQ-023 TxData SHALL equal hold throughout ISSUE and SHIFT; it is unchanged while the SSP logic shifts bits.
REQ-024 SHIFT to DONE when transmit_complete=1 is sampled.
REQ-025 In DONE, done[owner] pulses for one cycle, gnt clears, last_id is set to owner, and the FSM returns to IDLE.
REQ-026 Dropping req during ISSUE or SHIFT SHALL be ignored; the transfer completes.
REQ-027 A requester still holding req after done re-enters arbitration at the lowest round-robin priority.
REQ-028 rx_ready SHALL pass through a 2-flop synchroniser; its synchronised rising edge pulses rx_valid, captures RxData into rx_data, and sets rx_id to last_id.
REQ-029 An rx edge in any FSM state, including DONE, SHALL be processed independently and SHALL NOT be lost.

Reset
REQ-030 PRESETn low: state=IDLE; gnt, done, err, busy, tx_ready, rx_valid = 0; TxData, rx_data, rx_id, hold, timer and synchroniser = 0; last_id=NREQ-1, so requester 0 wins first.
REQ-031 Reset asserted mid-transfer SHALL drop tx_ready immediately and abandon the transfer with no done or err pulse.

Configuration
REQ-032 With macro SSP_ARB_TIMEOUT_EN defined, a timer SHALL count cycles in ISSUE and SHIFT, clear on entering ISSUE, and on reaching TIMEOUT_CYC pulse err[owner], clear gnt and tx_ready, leave last_id = owner, and return to IDLE.
REQ-033 Without SSP_ARB_TIMEOUT_EN, no timer SHALL exist, err is tied to 0, and ISSUE and SHIFT wait indefinitely.

Structure
REQ-034 Package ssp_pkg SHALL hold the FSM state encoding, the default NREQ, the default TIMEOUT_CYC and the ID width function.
REQ-035 Round-robin selection SHALL be a sub-module ssp_rr_arbiter with inputs req and last_id and outputs one-hot and index, combinational only.

Verification
REQ-036 Single request: req[2]=1 with byte 0xA5 -> tx_ready high one cycle later with TxData=0xA5; gnt=4'b0100 until done[2] pulses after transmit_complete returns high.
REQ-037 Contention: req=4'b1111 held after reset -> grants in order 0,1,2,3,0, one done pulse each, no overlapping gnt.
REQ-038 Receive: rx_ready rises after a transfer owned by requester 1, RxData=0x3C -> one rx_valid pulse 2-3 cycles later with rx_data=0x3C and rx_id=1.
REQ-039 Timeout (macro on, TIMEOUT_CYC=32): transmit_complete held high -> err[owner] pulses at cycle 32, FSM returns to IDLE, no done pulse.
REQ-040 Reset mid-SHIFT: PRESETn low -> tx_ready, gnt and busy go 0 immediately; after release, requester 0 is granted first.
